// File: rtl/demux_1_to_n_response_cache_pkg.sv
// Shared types for the cache response return path: response beats and per-lane FIFO status.
package demux_1_to_n_response_cache_pkg;
   localparam int RESPONSE_DEMUX_SETUP_CYCLES = 4;
   localparam int RESPONSE_DATA_W             = 32;

   typedef struct packed {
      logic [7:0] id_receiver;
   } MemoryPacketMeta;

   typedef struct packed {
      MemoryPacketMeta            meta;
      logic [RESPONSE_DATA_W-1:0] data;
   } MemoryPacketResponsePayload;

   typedef struct packed {
      logic                       valid;
      MemoryPacketResponsePayload payload;
   } MemoryPacketResponse;

   typedef struct packed {
      logic rd_en;
   } FIFOStateSignalsInput;

   typedef struct packed {
      logic empty;
      logic prog_full;
   } FIFOStateSignalsOutput;

   typedef struct packed {
      logic empty;
      logic full;
      logic prog_full;
   } FIFOStateSignalsOutputInternal;

   function automatic FIFOStateSignalsOutput map_internal_fifo_signals_to_output(
      input FIFOStateSignalsOutputInternal s);
      FIFOStateSignalsOutput o;
      o.empty     = s.empty;
      o.prog_full = s.prog_full;
      return o;
   endfunction
endpackage

// File: rtl/demux_1_to_n_response_cache_fifo.sv
// Synchronous FIFO with async reset and registered read: dout/valid one cycle after a pop.
// Writes while full are discarded; prog_full is count >= PROG_THRESH.
module fifo_sync_async_reset #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 16,
   parameter int PROG_THRESH = 12
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             valid_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             prog_full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] dout_q;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             valid_q;
   logic             wr_ok, rd_ok;

   assign full_o      = (count_q == (AW+1)'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign prog_full_o = (count_q >= (AW+1)'(PROG_THRESH));
   assign wr_ok       = wr_en_i & ~full_o;
   assign rd_ok       = rd_en_i & ~empty_o;
   assign count_d     = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
   assign dout_o      = dout_q;
   assign valid_o     = valid_q;

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         valid_q <= rd_ok;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= din_i;
      if (rd_ok) dout_q <= mem_q[rd_ptr_q];
   end
endmodule

// File: rtl/demux_1_to_n_response_cache.sv
// Cache response demux: steers beats by meta.id_receiver into per-lane FIFOs (2 register stages in).
// Ready is registered and drops while setting up or when any lane reaches prog_full.
module demux_1_to_n_response_cache
   import demux_1_to_n_response_cache_pkg::*;
#(
   parameter int NUM_MEMORY_RECEIVER = 2,
   parameter int ID_WIDTH            = (NUM_MEMORY_RECEIVER > 1) ? $clog2(NUM_MEMORY_RECEIVER) : 1,
   parameter int FIFO_RESPONSE_DEPTH = 16,
   parameter int PROG_THRESH         = 12,
   parameter int SETUP_CYCLES        = RESPONSE_DEMUX_SETUP_CYCLES
) (
   input  logic                                            ap_clk,
   input  logic                                            areset,
   input  MemoryPacketResponse                             response_in,
   output logic                                            response_ready_out,
   input  FIFOStateSignalsInput  [NUM_MEMORY_RECEIVER-1:0] fifo_response_signals_in,
   output FIFOStateSignalsOutput [NUM_MEMORY_RECEIVER-1:0] fifo_response_signals_out,
   output MemoryPacketResponse   [NUM_MEMORY_RECEIVER-1:0] response_out,
   output logic [15:0]                                     drop_count_out,
   output logic                                            fifo_setup_signal
);
   localparam int                PW    = $bits(MemoryPacketResponsePayload);
   localparam int                CW    = $clog2(SETUP_CYCLES + 1);
   localparam logic [ID_WIDTH:0] NUM_L = (ID_WIDTH+1)'(NUM_MEMORY_RECEIVER);

   logic [CW-1:0]                        setup_cnt_q, setup_cnt_d;
   logic                                 setup_q;
   logic                                 in_vld_q;
   MemoryPacketResponsePayload           in_pay_q, din_q;
   logic [ID_WIDTH-1:0]                  id;
   logic                                 in_range;
   logic [NUM_MEMORY_RECEIVER-1:0]       wr_dec, wr_en_q;
   logic [15:0]                          drop_q;
   logic                                 ready_q;
   logic [NUM_MEMORY_RECEIVER-1:0]       fifo_valid, fifo_empty, fifo_full, fifo_pf;
   logic [PW-1:0]                        fifo_dout [NUM_MEMORY_RECEIVER];
   FIFOStateSignalsOutputInternal [NUM_MEMORY_RECEIVER-1:0] stat_int;
   FIFOStateSignalsOutput [NUM_MEMORY_RECEIVER-1:0] stat_q;

   assign setup_cnt_d = setup_cnt_q + CW'(1);

   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         setup_cnt_q <= '0;
         setup_q     <= 1'b1;
      end else if (setup_q) begin
         setup_cnt_q <= setup_cnt_d;
         if (setup_cnt_d == CW'(SETUP_CYCLES)) setup_q <= 1'b0;
      end
   end

   // Payload registers carry no reset; only the valid/enable bits need one.
   always_ff @(posedge ap_clk) begin
      in_pay_q <= response_in.payload;
      din_q    <= in_pay_q;
   end

   assign id       = in_pay_q.meta.id_receiver[ID_WIDTH-1:0];
   assign in_range = ({1'b0, id} < NUM_L);

   always_comb begin
      wr_dec = '0;
      for (int i = 0; i < NUM_MEMORY_RECEIVER; i++) begin
         wr_dec[i] = in_vld_q & in_range & (id == ID_WIDTH'(i));
         stat_int[i] = '{empty: fifo_empty[i], full: fifo_full[i], prog_full: fifo_pf[i]};
      end
   end

   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         in_vld_q <= 1'b0;
         wr_en_q  <= '0;
         drop_q   <= '0;
         ready_q  <= 1'b0;
         stat_q   <= {NUM_MEMORY_RECEIVER{2'b10}};
      end else begin
         in_vld_q <= response_in.valid & ~setup_q;
         wr_en_q  <= wr_dec;
         if (in_vld_q && !in_range && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         ready_q  <= ~setup_q & ~(|(fifo_pf | fifo_full));
         for (int i = 0; i < NUM_MEMORY_RECEIVER; i++)
            stat_q[i] <= map_internal_fifo_signals_to_output(stat_int[i]);
      end
   end

   for (genvar g = 0; g < NUM_MEMORY_RECEIVER; g++) begin : g_lane
      fifo_sync_async_reset #(
         .WIDTH       (PW),
         .DEPTH       (FIFO_RESPONSE_DEPTH),
         .PROG_THRESH (PROG_THRESH)
      ) u_fifo (
         .clk_i       (ap_clk),
         .rst_i       (areset),
         .wr_en_i     (wr_en_q[g]),
         .din_i       (din_q),
         .rd_en_i     (fifo_response_signals_in[g].rd_en),
         .dout_o      (fifo_dout[g]),
         .valid_o     (fifo_valid[g]),
         .empty_o     (fifo_empty[g]),
         .full_o      (fifo_full[g]),
         .prog_full_o (fifo_pf[g])
      );
      assign response_out[g] = {fifo_valid[g], fifo_dout[g]};
   end

   assign response_ready_out        = ready_q;
   assign fifo_response_signals_out = stat_q;
   assign drop_count_out            = drop_q;
   assign fifo_setup_signal         = setup_q;
endmodule

// File: doc/demux_1_to_n_response_cache.md
Name: demux_1_to_N_response_cache

Overview:
- Return path of the cache request arbiter.
- Accepts one stream of MemoryPacketResponse beats from the cache/memory side and steers each beat to one of N requestor lanes by the ID in its meta field.
- Each lane buffers beats in its own FIFO and is drained independently by its engine with rd_en.
- A single ready signal throttles the cache side. A bring-up counter provides the setup signal.

Parameters:
- NUM_MEMORY_RECEIVER, 2, number of output lanes (requestors).
- ID_WIDTH, max(1,$clog2(NUM_MEMORY_RECEIVER)), width of the routing ID taken from payload.meta.id_receiver[ID_WIDTH-1:0].
- FIFO_RESPONSE_DEPTH, 16, per-lane FIFO depth; must be a power of 2 and ≥4.
- PROG_THRESH, 12, per-lane occupancy at or above which prog_full asserts.
- SETUP_CYCLES, 4, number of cycles setup is held after reset release.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- response_in  in  $bits(MemoryPacketResponse)  response beat from the cache; valid plus payload.
- response_ready_out  out  1  upstream may present a beat in the next cycle.
- fifo_response_signals_in  in  NUM_MEMORY_RECEIVER x FIFOStateSignalsInput  per-lane rd_en from the engines.
- fifo_response_signals_out  out  NUM_MEMORY_RECEIVER x FIFOStateSignalsOutput  per-lane {empty, prog_full} status.
- response_out  out  NUM_MEMORY_RECEIVER x $bits(MemoryPacketResponse)  per-lane output beat.
- drop_count_out  out  16  saturating count of beats whose ID was out of range.
- fifo_setup_signal  out  1  high while the block is initialising.

Behaviour:
- Reset (async assert, sync release):
  - All valids 0, response_ready_out 0, fifo_setup_signal 1.
  - fifo_response_signals_out = {empty=1, prog_full=0} per lane.
  - drop_count_out 0; every FIFO pointer and count 0.
- Setup counter:
  - Counts from 0 after reset release.
  - fifo_setup_signal deasserts in the cycle the count reaches SETUP_CYCLES and stays low until the next reset.
  - While setup is high, response_ready_out=0 and input beats are ignored and not counted.
- Stage 0, input register: response_in.valid is registered with reset; payload is registered without reset.
- Stage 1, decode:
  - id = reg.payload.meta.id_receiver[ID_WIDTH-1:0].
  - If reg.valid and id < NUM_MEMORY_RECEIVER: wr_en[id]=1 and din[id]=payload.
  - If reg.valid and id ≥ NUM_MEMORY_RECEIVER (only possible when N is not a power of 2): no write anywhere; drop_count increments, saturating at 16'hFFFF.
  - Input-to-FIFO latency is 2 cycles.
- Per-lane FIFO:
  - Pop: rd_en_int[i] = fifo_response_signals_in[i].rd_en & ~empty[i].
  - Registered read, 1 cycle: response_out[i].valid=1 and payload valid in the cycle after rd_en_int.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
  - Pointers wrap modulo FIFO_RESPONSE_DEPTH.
  - A push while full is a protocol violation: the write is discarded and count is not changed.
  - prog_full[i] = count[i] ≥ PROG_THRESH.
- Backpressure:
  - response_ready_out is registered: ~setup & ~(|prog_full).
  - Slack: the 2 pipeline beats plus 1 ready-register beat must fit, so PROG_THRESH ≤ FIFO_RESPONSE_DEPTH-3 is required.
  - Upstream must not send when ready was low in the previous cycle.
- fifo_response_signals_out is registered one cycle after internal status.
- Reset mid-stream flushes all FIFOs and pipeline stages immediately; in-flight beats are lost.

Decomposition:
- global_package gains:
  - Field meta.id_receiver in MemoryPacketResponsePayload.
  - Helper map_internal_fifo_signals_to_output, already present.
  - Constant RESPONSE_DEMUX_SETUP_CYCLES.
- One sub-module, fifo_sync_async_reset:
  - Parameterised width, depth and prog threshold.
  - Outputs dout, valid, empty, full, prog_full.
  - Instantiated once per lane.
- The demux logic and the setup counter stay in the top module.

Test Plan:
- Reset release, no traffic → fifo_setup_signal=1 for cycles 0..3 after release and 0 from cycle 4; response_ready_out goes high at cycle 5; all lanes empty=1.
- N=2: beat id=1 payload 0xA5 sent, lane 1 rd_en held high → response_out[1].valid=1 with 0xA5 exactly 4 cycles after input valid; lane 0 never valid.
- N=2, depth 16, thresh 12: 13 beats to lane 0 with rd_en=0 → prog_full[0] visible at the output, response_ready_out=0; no loss; draining returns all 13 beats in order.
- N=3: 5 beats with id=3 interleaved with 5 beats with id=2 → drop_count_out=5; lane 2 receives exactly 5 beats in order.
- Same-cycle push and pop on lane 1 at count=8 for 20 cycles → count stays 8, empty=0, data order preserved across pointer wrap.
- Assert areset for 1 cycle while lane 0 holds 6 beats → all valids drop immediately (asynchronously); after release lane 0 empty=1 and drop_count_out=0.
